// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator datapath types, constants and helpers
package calc_pkg;

  localparam int MULT_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } mult_state_t;

  // Magnitude of a (msb+1)-bit operand held zero-extended in 32 bits.
  function automatic logic [31:0] abs_val(input logic [31:0] value,
                                          input logic        signed_mode,
                                          input logic [4:0]  msb);
    logic [31:0] mask;
    mask = (msb == 5'd31) ? 32'hFFFF_FFFF
                          : ((32'd1 << ({1'b0, msb} + 6'd1)) - 32'd1);
    if (signed_mode && value[msb]) begin
      abs_val = (~value + 32'd1) & mask;
    end else begin
      abs_val = value & mask;
    end
  endfunction

endpackage

// File: rtl/mult_add_stage.sv
// rtl/mult_add_stage.sv - WIDTH-bit adder with carry-out
module mult_add_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add signed/unsigned multiplier
module seq_multiplier
  import calc_pkg::*;
#(
  parameter  int WIDTH = MULT_DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  mult_state_t state, next_state;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] prod;
  logic               last_iter;

  assign a_mag     = WIDTH'(abs_val(32'(a), signed_mode, 5'(WIDTH - 1)));
  assign b_mag     = WIDTH'(abs_val(32'(b), signed_mode, 5'(WIDTH - 1)));
  assign partial   = mq[0] ? {carry, sum} : {1'b0, acc};
  assign prod      = {acc, mq};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state != IDLE);

  mult_add_stage #(.WIDTH(WIDTH)) u_add (
    .x     (acc),
    .y     (mcand),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (last_iter) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Product bits shift out of acc into the vacated multiplier positions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mq    <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      p     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a_mag;
            mq    <= b_mag;
            acc   <= '0;
            cnt   <= '0;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        CALC: begin
          acc <= partial[WIDTH:1];
          mq  <= {partial[0], mq[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          p    <= neg ? (~prod + 1'b1) : prod;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
